// File: rtl/relu_pool_emit_pkg.sv
// Shared constants and types for the ReLU / max-pool / emit stage.
// Optional feature macro: RELU_POOL_ROUND_EN (round-half-up after the shift).
package relu_pool_emit_pkg;

    // Default value width and frame geometry used by the surrounding datapath.
    localparam int DATA_LEN_DEF = 16;
    localparam int CH_NUM       = 32;
    localparam int POS_NUM      = 12;

    // IDLE waits for a frame, EMIT streams one channel row per handshake.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/relu_pool_emit_max2.sv
// relu_max2: ReLU on two signed values, keep the larger, then scale down by SHIFT.
// With RELU_POOL_ROUND_EN defined the scaling rounds half-up and saturates;
// otherwise it is a plain truncating right shift.
module relu_max2 #(
    parameter int DATA_LEN = 16,
    parameter int SHIFT    = 0
) (
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] y
);

    logic [DATA_LEN-1:0] relu_a;
    logic [DATA_LEN-1:0] relu_b;
    logic [DATA_LEN-1:0] pool_max;

    // Negative inputs clamp to zero; once both are nonnegative an unsigned
    // compare gives the same ordering as a signed one.
    always_comb begin
        relu_a   = a[DATA_LEN-1] ? '0 : a;
        relu_b   = b[DATA_LEN-1] ? '0 : b;
        pool_max = (relu_a > relu_b) ? relu_a : relu_b;
    end

`ifdef RELU_POOL_ROUND_EN
    generate
        if (SHIFT == 0) begin : g_no_shift
            assign y = pool_max;
        end else begin : g_round
            localparam logic [DATA_LEN:0] HALF  = (DATA_LEN + 1)'(2 ** (SHIFT - 1));
            localparam logic [DATA_LEN:0] MAX_V = {2'b00, {(DATA_LEN - 1){1'b1}}};
            logic [DATA_LEN:0] sum;
            logic [DATA_LEN:0] scaled;
            assign sum    = {1'b0, pool_max} + HALF;
            assign scaled = sum >> SHIFT;
            assign y      = (scaled > MAX_V) ? MAX_V[DATA_LEN-1:0] : scaled[DATA_LEN-1:0];
        end
    endgenerate
`else
    assign y = pool_max >> SHIFT;
`endif

endmodule

// File: rtl/relu_pool_emit.sv
// relu_pool_emit: captures a CH x POS frame, applies ReLU + pairwise max-pool + shift,
// and streams the pooled frame one channel row per out_valid/out_ready handshake.
// Optional feature macro: RELU_POOL_ROUND_EN (handled inside relu_max2).
module relu_pool_emit
    import relu_pool_emit_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int CH       = CH_NUM,
    parameter int POS      = POS_NUM,
    parameter int SHIFT    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH*POS*DATA_LEN-1:0]     d,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(CH)-1:0]          out_ch,
    output logic [(POS/2)*DATA_LEN-1:0]    out_data,
    output logic                           done
);

    localparam int CH_W  = $clog2(CH);
    localparam int ROW_W = (POS / 2) * DATA_LEN;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH - 1);

    state_t                    state;
    state_t                    state_next;
    logic                      alive;
    logic                      capture;
    logic                      advance;
    logic                      last_row;
    logic [CH-1:0][ROW_W-1:0]  pooled;
    logic [CH-1:0][ROW_W-1:0]  store;

    // One pooling cell per adjacent position pair of every channel.
    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            for (genvar k = 0; k < POS / 2; k++) begin : g_pair
                relu_max2 #(
                    .DATA_LEN(DATA_LEN),
                    .SHIFT   (SHIFT)
                ) u_max2 (
                    .a(d[(POS*c + 2*k)*DATA_LEN +: DATA_LEN]),
                    .b(d[(POS*c + 2*k + 1)*DATA_LEN +: DATA_LEN]),
                    .y(pooled[c][k*DATA_LEN +: DATA_LEN])
                );
            end
        end
    endgenerate

    // alive holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode; the last row accept returns to IDLE with a bubble.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        last_row   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = alive;
                if (alive && in_valid) begin
                    capture    = 1'b1;
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    advance = 1'b1;
                    if (out_ch == LAST_CH) begin
                        last_row   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Row counter restarts at 0 on every capture and only steps on an accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   out_ch <= '0;
        else if (capture)             out_ch <= '0;
        else if (advance && !last_row) out_ch <= out_ch + 1'b1;
    end

    // done pulses for one cycle after the final row has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= last_row;
    end

    // Frame store takes the whole pooled frame in the capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       store <= '0;
        else if (capture) store <= pooled;
    end

    assign out_data = out_valid ? store[out_ch] : '0;

endmodule

// File: tb/tb_relu_pool_emit.sv
// Self-checking bench for relu_pool_emit: one SHIFT=0 and one SHIFT=2 instance
// share the same stimulus and are checked every cycle against a frame-level model.
module tb_relu_pool_emit;

    localparam int DL   = 16;
    localparam int CH   = 32;
    localparam int POS  = 12;
    localparam int HALF = POS / 2;
    localparam int CW   = $clog2(CH);

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   out_ready;
    logic [CH*POS*DL-1:0]   d;

    logic                   in_ready0, out_valid0, done0;
    logic [CW-1:0]          out_ch0;
    logic [HALF*DL-1:0]     out_data0;
    logic                   in_ready2, out_valid2, done2;
    logic [CW-1:0]          out_ch2;
    logic [HALF*DL-1:0]     out_data2;

    int vectors   = 0;
    int miscompares = 0;

    // Model state
    logic m_alive, m_emit, m_done;
    int   m_ch;
    int   exp0 [CH][HALF];
    int   exp2 [CH][HALF];

    relu_pool_emit #(.DATA_LEN(DL), .CH(CH), .POS(POS), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .d(d),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ch(out_ch0),
        .out_data(out_data0), .done(done0)
    );

    relu_pool_emit #(.DATA_LEN(DL), .CH(CH), .POS(POS), .SHIFT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .d(d),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ch(out_ch2),
        .out_data(out_data2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pooled result of one pair from the arithmetic definition.
    function automatic int calc(input int a, input int b, input int s);
        int ra, rb, y;
        ra = (a < 0) ? 0 : a;
        rb = (b < 0) ? 0 : b;
        y  = (ra > rb) ? ra : rb;
`ifdef RELU_POOL_ROUND_EN
        if (s > 0) begin
            y = (y + (1 << (s - 1))) >> s;
            if (y > 32767) y = 32767;
        end
`else
        y = y >> s;
`endif
        return y;
    endfunction

    task automatic check_output(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Frame-level reference: capture the whole pooled frame, then walk rows on handshakes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_alive <= 1'b0;
            m_emit  <= 1'b0;
            m_done  <= 1'b0;
            m_ch    <= 0;
        end else begin
            m_done  <= 1'b0;
            m_alive <= 1'b1;
            if (!m_emit) begin
                if (m_alive && in_valid) begin
                    for (int c = 0; c < CH; c++) begin
                        for (int k = 0; k < HALF; k++) begin
                            exp0[c][k] <= calc(int'($signed(d[(POS*c + 2*k)*DL +: DL])),
                                               int'($signed(d[(POS*c + 2*k + 1)*DL +: DL])), 0);
                            exp2[c][k] <= calc(int'($signed(d[(POS*c + 2*k)*DL +: DL])),
                                               int'($signed(d[(POS*c + 2*k + 1)*DL +: DL])), 2);
                        end
                    end
                    m_emit <= 1'b1;
                    m_ch   <= 0;
                end
            end else if (out_ready) begin
                if (m_ch == CH - 1) begin
                    m_emit <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_ch <= m_ch + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check_output("in_ready0",  int'(in_ready0),  int'(m_alive && !m_emit));
        check_output("out_valid0", int'(out_valid0), int'(m_emit));
        check_output("done0",      int'(done0),      int'(m_done));
        check_output("in_ready2",  int'(in_ready2),  int'(m_alive && !m_emit));
        check_output("out_valid2", int'(out_valid2), int'(m_emit));
        check_output("done2",      int'(done2),      int'(m_done));
        if (m_emit) begin
            check_output("out_ch0", int'(out_ch0), m_ch);
            check_output("out_ch2", int'(out_ch2), m_ch);
            for (int k = 0; k < HALF; k++) begin
                check_output("row0_word", int'(out_data0[k*DL +: DL]), exp0[m_ch][k]);
                check_output("row2_word", int'(out_data2[k*DL +: DL]), exp2[m_ch][k]);
            end
        end
    end

    task automatic step_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_val(input int c, input int p, input int v);
        d[(POS*c + p)*DL +: DL] = DL'(v);
    endtask

    task automatic random_frame();
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < POS; p++)
                set_val(c, p, int'($urandom_range(0, 65535)) - 32768);
    endtask

    // Raise in_valid once the block is ready and drop it after the capture edge.
    task automatic apply_stimulus();
        int n;
        n = 0;
        while (!in_ready0 && n < 100) begin
            step_cycle();
            n++;
        end
        if (!in_ready0) check_output("ready_timeout", 0, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready, input bit rand_valid);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (rand_valid) begin
                in_valid = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) random_frame();
            end
            step_cycle();
            if (done0) seen = 1'b1;
        end
        if (!seen) check_output("done_timeout", 0, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        d         = '0;

        // Hand-computed pins on the model itself.
        check_output("model_neg_pair", calc(-5, -1, 0), 0);
        check_output("model_extreme_pair", calc(-32768, 32767, 0), 32767);
`ifdef RELU_POOL_ROUND_EN
        check_output("model_shift2_six", calc(6, 3, 2), 2);
        check_output("model_shift2_max", calc(32767, 0, 2), 8192);
`else
        check_output("model_shift2_six", calc(6, 3, 2), 1);
        check_output("model_shift2_max", calc(32767, 0, 2), 8191);
`endif

        repeat (3) step_cycle();
        check_output("reset_in_ready", int'(in_ready0), 0);
        check_output("reset_out_ch", int'(out_ch0), 0);
        check_output("reset_out_data", int'(out_data0 != '0), 0);
        rst_n = 1'b1;
        step_cycle();
        check_output("post_reset_in_ready", int'(in_ready0), 1);

        // Reset in the middle of emitting a frame.
        $display("[TB] mid-frame reset");
        random_frame();
        apply_stimulus();
        repeat (3) step_cycle();
        rst_n = 1'b0;
        #1;
        check_output("midreset_out_valid", int'(out_valid0), 0);
        check_output("midreset_done", int'(done0), 0);
        check_output("midreset_in_ready", int'(in_ready0), 0);
        repeat (2) step_cycle();
        rst_n = 1'b1;
        step_cycle();
        check_output("midreset_release_ready", int'(in_ready0), 1);

        // Ramp frame, continuous acceptance.
        $display("[TB] ramp frame");
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < POS; p++)
                set_val(c, p, c + p - 6);
        out_ready = 1'b1;
        apply_stimulus();
        check_output("ramp_latency_valid", int'(out_valid0), 1);
        check_output("ramp_row0_ch", int'(out_ch0), 0);
        check_output("ramp_row0_data", int'(out_data0 == {16'd5, 16'd3, 16'd1, 16'd0, 16'd0, 16'd0}), 1);
        repeat (32) step_cycle();
        check_output("ramp_done_timing", int'(done0), 1);

        // Random frames under random backpressure and stray in_valid pulses.
        $display("[TB] backpressure");
        for (int f = 0; f < 4; f++) begin
            random_frame();
            apply_stimulus();
            wait_done(600, 1'b1, 1'b1);
            in_valid = 1'b0;
            step_cycle();
        end

        // Boundary pairs on channel 0.
        $display("[TB] boundary pairs");
        random_frame();
        set_val(0, 0, -5);
        set_val(0, 1, -1);
        set_val(0, 2, -32768);
        set_val(0, 3, 32767);
        set_val(0, 4, 6);
        set_val(0, 5, 3);
        out_ready = 1'b1;
        apply_stimulus();
        check_output("pair_neg", int'(out_data0[0 +: DL]), 0);
        check_output("pair_extreme", int'(out_data0[DL +: DL]), 32767);
`ifdef RELU_POOL_ROUND_EN
        check_output("shift2_max", int'(out_data2[DL +: DL]), 8192);
        check_output("shift2_six", int'(out_data2[2*DL +: DL]), 2);
`else
        check_output("shift2_max", int'(out_data2[DL +: DL]), 8191);
        check_output("shift2_six", int'(out_data2[2*DL +: DL]), 1);
`endif
        wait_done(100, 1'b0, 1'b0);

        // Back-to-back frames with in_valid held high.
        $display("[TB] back-to-back");
        random_frame();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_done(100, 1'b0, 1'b0);
        check_output("b2b_ready_at_done", int'(in_ready0), 1);
        random_frame();
        step_cycle();
        check_output("b2b_second_valid", int'(out_valid0), 1);
        check_output("b2b_second_ch", int'(out_ch0), 0);
        in_valid = 1'b0;
        wait_done(100, 1'b0, 1'b0);
        repeat (3) step_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
